// File: rtl/tri_pkg.sv
// tri_pkg: shared definitions for the triangle write buffer.
//   - mem_wr_en command codes driven by the memory controller
//   - FSM state type for the buffer's session control
//   - default word width of the controller's triangle write path
package tri_pkg;

  localparam int DEFAULT_DATA_WIDTH = 128;

  // Command codes on mem_wr_en; 2'b11 is reserved and ignored.
  localparam logic [1:0] MC_WR_IDLE = 2'b00;
  localparam logic [1:0] MC_WR_DATA = 2'b01;
  localparam logic [1:0] MC_WR_DONE = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } tri_buf_state_t;

endpackage : tri_pkg

// File: rtl/tri_fifo.sv
// tri_fifo: synchronous FIFO with a registered occupancy count and a
// combinational head read (no bypass: a pushed word is visible only after
// the edge that stores it).
// Ports:
//   clk, rst    clock, asynchronous active-high reset (empties the FIFO)
//   push_i      write wdata_i; honoured when not full or when popping too
//   pop_i       remove the head entry; ignored when empty
//   wdata_i     data to push
//   rdata_o     head entry (valid when !empty_o)
//   full_o      DEPTH entries held
//   empty_o     no entries held
//   count_o     current occupancy, 0..DEPTH
module tri_fifo #(
  parameter int DATA_WIDTH = tri_pkg::DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [DATA_WIDTH-1:0]    wdata_i,
  output logic [DATA_WIDTH-1:0]    rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q;
  logic [PTR_W-1:0]      rd_ptr_q;
  logic [CNT_W-1:0]      count_q;
  logic                  do_push;
  logic                  do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // NOTE: storage has no reset; only pointers and count define validity, so
  // resetting the array would just cost flops and routing.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // DEPTH is a power of two, so pointer wrap is the natural overflow.
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule : tri_fifo

// File: rtl/tri_wr_buffer.sv
// tri_wr_buffer: downstream consumer of the memory controller's triangle
// write path. Buffers incoming words, drains them to triangle memory at
// sequential addresses under a grant handshake, and reports triangle count
// and session completion.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   mem_wr_en         00 idle, 01 write word, 10 load done, 11 ignored
//   mem_wr_data_128   word, valid with 01
//   mem_wr_rdy_tri    registered flow control back to the controller
//   tri_we            memory write request (FIFO not empty)
//   tri_addr          memory write address
//   tri_wdata         memory write data (FIFO head)
//   tri_wr_gnt        memory accepts the write this cycle
//   tri_count         completed triangles written this session
//   load_done         one-cycle pulse when the session has fully drained
//   busy              session in LOAD or DRAIN
//   err_ovf           sticky: word dropped because the FIFO was full
//   err_proto         sticky: write outside IDLE/LOAD or partial triangle
module tri_wr_buffer
  import tri_pkg::*;
#(
  parameter int                    DATA_WIDTH    = DEFAULT_DATA_WIDTH,
  parameter int                    DEPTH         = 8,
  parameter int                    ADDR_WIDTH    = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR     = '0,
  parameter int                    WORDS_PER_TRI = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            mem_wr_en,
  input  logic [DATA_WIDTH-1:0] mem_wr_data_128,
  output logic                  mem_wr_rdy_tri,
  output logic                  tri_we,
  output logic [ADDR_WIDTH-1:0] tri_addr,
  output logic [DATA_WIDTH-1:0] tri_wdata,
  input  logic                  tri_wr_gnt,
  output logic [ADDR_WIDTH-1:0] tri_count,
  output logic                  load_done,
  output logic                  busy,
  output logic                  err_ovf,
  output logic                  err_proto
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int WC_W  = (WORDS_PER_TRI > 1) ? $clog2(WORDS_PER_TRI) : 1;

  tri_buf_state_t        state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] tri_cnt_q, tri_cnt_d;
  logic [WC_W-1:0]       wcnt_q, wcnt_d;
  logic                  ovf_q, ovf_d;
  logic                  proto_q, proto_d;
  logic                  rdy_q, rdy_d;

  logic                  fifo_full, fifo_empty;
  logic [CNT_W-1:0]      fifo_count;
  logic [DATA_WIDTH-1:0] fifo_rdata;

  logic                  is_data, is_done, accepting;
  logic                  push_req, push_ok, pop, session_start;
  logic [CNT_W-1:0]      occ_next;

  tri_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_ok),
    .pop_i   (pop),
    .wdata_i (mem_wr_data_128),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    is_data       = (mem_wr_en == MC_WR_DATA);
    is_done       = (mem_wr_en == MC_WR_DONE);
    accepting     = (state_q == ST_IDLE) || (state_q == ST_LOAD);
    pop           = !fifo_empty && tri_wr_gnt;
    push_req      = is_data && accepting;
    push_ok       = push_req && (!fifo_full || pop);
    session_start = (state_q == ST_IDLE) && (is_data || is_done);
    occ_next      = fifo_count + CNT_W'(push_ok) - CNT_W'(pop);
    // One spare entry absorbs the word the producer may send in the cycle
    // it takes to see ready fall.
    rdy_d         = (occ_next <= CNT_W'(DEPTH - 2));
  end

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // through the block can leave it unassigned and infer a latch.
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (is_data)      state_d = ST_LOAD;
        else if (is_done) state_d = ST_DONE;
      end
      ST_LOAD:  if (is_done) state_d = ST_DRAIN;
      ST_DRAIN: if (fifo_empty) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    addr_d    = addr_q;
    wcnt_d    = wcnt_q;
    tri_cnt_d = tri_cnt_q;
    ovf_d     = ovf_q;
    proto_d   = proto_q;

    // The FIFO is always empty in IDLE, so a session start never coincides
    // with a pop and the clear below cannot lose an update.
    if (session_start) begin
      addr_d    = BASE_ADDR;
      wcnt_d    = '0;
      tri_cnt_d = '0;
      ovf_d     = 1'b0;
      proto_d   = 1'b0;
    end

    // Triangles are counted as they land in memory, not as they arrive.
    if (pop) begin
      addr_d = addr_q + 1'b1;
      if (wcnt_q == WC_W'(WORDS_PER_TRI - 1)) begin
        wcnt_d    = '0;
        tri_cnt_d = tri_cnt_q + 1'b1;
      end else begin
        wcnt_d = wcnt_q + 1'b1;
      end
    end

    if (push_req && !push_ok)                  ovf_d   = 1'b1;
    if (is_data && !accepting)                 proto_d = 1'b1;
    if ((state_q == ST_DONE) && (wcnt_q != '0)) proto_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      addr_q    <= BASE_ADDR;
      wcnt_q    <= '0;
      tri_cnt_q <= '0;
      ovf_q     <= 1'b0;
      proto_q   <= 1'b0;
      rdy_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wcnt_q    <= wcnt_d;
      tri_cnt_q <= tri_cnt_d;
      ovf_q     <= ovf_d;
      proto_q   <= proto_d;
      rdy_q     <= rdy_d;
    end
  end

  assign mem_wr_rdy_tri = rdy_q;
  assign tri_we         = !fifo_empty;
  assign tri_wdata      = fifo_rdata;
  assign tri_addr       = addr_q;
  assign tri_count      = tri_cnt_q;
  assign load_done      = (state_q == ST_DONE);
  assign busy           = (state_q == ST_LOAD) || (state_q == ST_DRAIN);
  assign err_ovf        = ovf_q;
  assign err_proto      = proto_q;

endmodule : tri_wr_buffer

// File: tb/tb_tri_wr_buffer.sv
// Self-checking bench for tri_wr_buffer. A session-level reference model
// (word queue, pop count, sticky flags, session phase) predicts every
// observable output; scenario tasks check the directed cases and a
// randomized task compares all outputs every cycle.
module tb_tri_wr_buffer;

  localparam int          DW    = 128;
  localparam int          DEPTH = 8;
  localparam int          AW    = 16;
  localparam logic [15:0] BASE  = 16'h0000;
  localparam int          WPT   = 3;

  localparam int PH_IDLE  = 0;
  localparam int PH_LOAD  = 1;
  localparam int PH_DRAIN = 2;
  localparam int PH_DONE  = 3;

  logic          clk;
  logic          rst;
  logic [1:0]    mem_wr_en;
  logic [DW-1:0] mem_wr_data_128;
  logic          mem_wr_rdy_tri;
  logic          tri_we;
  logic [AW-1:0] tri_addr;
  logic [DW-1:0] tri_wdata;
  logic          tri_wr_gnt;
  logic [AW-1:0] tri_count;
  logic          load_done;
  logic          busy;
  logic          err_ovf;
  logic          err_proto;

  int n_cmp = 0;
  int n_err = 0;
  int ld_pulses = 0;

  // Reference model state
  logic [DW-1:0] mq[$];
  int            m_pops;
  bit            m_ovf, m_proto;
  int            m_phase;

  tri_wr_buffer #(
    .DATA_WIDTH    (DW),
    .DEPTH         (DEPTH),
    .ADDR_WIDTH    (AW),
    .BASE_ADDR     (BASE),
    .WORDS_PER_TRI (WPT)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .mem_wr_en       (mem_wr_en),
    .mem_wr_data_128 (mem_wr_data_128),
    .mem_wr_rdy_tri  (mem_wr_rdy_tri),
    .tri_we          (tri_we),
    .tri_addr        (tri_addr),
    .tri_wdata       (tri_wdata),
    .tri_wr_gnt      (tri_wr_gnt),
    .tri_count       (tri_count),
    .load_done       (load_done),
    .busy            (busy),
    .err_ovf         (err_ovf),
    .err_proto       (err_proto)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] exp_addr();
    return BASE + 16'(m_pops);
  endfunction

  function automatic logic [15:0] exp_count();
    return 16'(m_pops / WPT);
  endfunction

  task automatic model_reset();
    mq.delete();
    m_pops  = 0;
    m_ovf   = 1'b0;
    m_proto = 1'b0;
    m_phase = PH_IDLE;
  endtask

  // Session rules applied to one clock edge with the given inputs.
  task automatic model_update(input logic [1:0] en, input logic [DW-1:0] d, input logic g);
    bit is_data, is_done, was_empty, was_full, pop, accepting;
    is_data   = (en == 2'b01);
    is_done   = (en == 2'b10);
    was_empty = (mq.size() == 0);
    was_full  = (mq.size() == DEPTH);
    pop       = !was_empty && g;
    accepting = (m_phase == PH_IDLE) || (m_phase == PH_LOAD);
    if (m_phase == PH_IDLE && (is_data || is_done)) begin
      m_pops = 0; m_ovf = 1'b0; m_proto = 1'b0;
    end
    if (m_phase == PH_DONE && (m_pops % WPT) != 0) m_proto = 1'b1;
    if (pop) begin
      void'(mq.pop_front());
      m_pops++;
    end
    if (is_data && accepting) begin
      if (!was_full || pop) mq.push_back(d);
      else                  m_ovf = 1'b1;
    end
    if (is_data && !accepting) m_proto = 1'b1;
    case (m_phase)
      PH_IDLE:  if (is_data) m_phase = PH_LOAD; else if (is_done) m_phase = PH_DONE;
      PH_LOAD:  if (is_done) m_phase = PH_DRAIN;
      PH_DRAIN: if (was_empty) m_phase = PH_DONE;
      default:  m_phase = PH_IDLE;
    endcase
  endtask

  // Drive inputs from a falling edge, advance the model, land on the next
  // falling edge where outputs are stable.
  task automatic step(input logic [1:0] en, input logic [DW-1:0] d, input logic g);
    mem_wr_en       = en;
    mem_wr_data_128 = d;
    tri_wr_gnt      = g;
    model_update(en, d, g);
    @(posedge clk);
    @(negedge clk);
    if (load_done === 1'b1) ld_pulses++;
  endtask

  task automatic drain_until_idle(input logic g);
    int n;
    n = 0;
    while (m_phase != PH_IDLE && n < 64) begin
      step(2'b00, '0, g);
      n++;
    end
    n_cmp++;
    if (m_phase != PH_IDLE) begin
      n_err++;
      $display("FAIL drain_timeout: still busy after %0d cycles, required idle", n);
    end
  endtask

  task automatic test_reset();
    n_cmp += 7;
    if (mem_wr_rdy_tri !== 1'b1) begin n_err++; $display("FAIL reset_rdy: got %b want 1", mem_wr_rdy_tri); end
    if (tri_we !== 1'b0)         begin n_err++; $display("FAIL reset_we: got %b want 0", tri_we); end
    if (tri_addr !== BASE)       begin n_err++; $display("FAIL reset_addr: got %h want %h", tri_addr, BASE); end
    if (tri_count !== 16'd0)     begin n_err++; $display("FAIL reset_count: got %0d want 0", tri_count); end
    if (load_done !== 1'b0)      begin n_err++; $display("FAIL reset_done: got %b want 0", load_done); end
    if (busy !== 1'b0)           begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    if ({err_ovf, err_proto} !== 2'b00) begin n_err++; $display("FAIL reset_err: got %b want 00", {err_ovf, err_proto}); end
  endtask

  task automatic test_single_triangle();
    logic [DW-1:0] w[3];
    int p0;
    w[0] = {64'hCAFE_0000_0000_0001, 64'h0000_0000_0000_00A0};
    w[1] = {64'hCAFE_0000_0000_0002, 64'h0000_0000_0000_00A1};
    w[2] = {64'hCAFE_0000_0000_0003, 64'h0000_0000_0000_00A2};
    p0 = ld_pulses;
    for (int k = 0; k < 3; k++) begin
      step(2'b01, w[k], 1'b1);
      n_cmp += 3;
      if (tri_we !== 1'b1)        begin n_err++; $display("FAIL single_we%0d: got %b want 1", k, tri_we); end
      if (tri_wdata !== w[k])     begin n_err++; $display("FAIL single_data%0d: got %h want %h", k, tri_wdata, w[k]); end
      if (tri_addr !== 16'(k))    begin n_err++; $display("FAIL single_addr%0d: got %0d want %0d", k, tri_addr, k); end
    end
    step(2'b10, '0, 1'b1);
    drain_until_idle(1'b1);
    n_cmp += 4;
    if (tri_count !== 16'd1)      begin n_err++; $display("FAIL single_count: got %0d want 1", tri_count); end
    if (ld_pulses - p0 != 1)      begin n_err++; $display("FAIL single_pulses: got %0d want 1", ld_pulses - p0); end
    if ({err_ovf, err_proto} !== 2'b00) begin n_err++; $display("FAIL single_err: got %b want 00", {err_ovf, err_proto}); end
    if (tri_addr !== 16'd3)       begin n_err++; $display("FAIL single_end_addr: got %0d want 3", tri_addr); end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] w[8];
    for (int i = 0; i < 8; i++) w[i] = {32'hB0B0_0000 + 32'(i), 96'(i * 7 + 1)};
    for (int i = 0; i < 8; i++) begin
      step(2'b01, w[i], 1'b0);
      n_cmp++;
      if (mem_wr_rdy_tri !== ((i + 1) <= DEPTH - 2))
        begin n_err++; $display("FAIL bp_rdy%0d: got %b want %b", i + 1, mem_wr_rdy_tri, (i + 1) <= DEPTH - 2); end
    end
    n_cmp++;
    if (err_ovf !== 1'b0) begin n_err++; $display("FAIL bp_ovf_full: got %b want 0", err_ovf); end
    step(2'b01, {DW{1'b1}}, 1'b0);
    n_cmp += 2;
    if (err_ovf !== 1'b1)   begin n_err++; $display("FAIL bp_ovf_set: got %b want 1", err_ovf); end
    if (tri_wdata !== w[0]) begin n_err++; $display("FAIL bp_head: got %h want %h", tri_wdata, w[0]); end
    step(2'b10, '0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      n_cmp += 3;
      if (tri_we !== 1'b1)     begin n_err++; $display("FAIL bp_we%0d: got %b want 1", k, tri_we); end
      if (tri_wdata !== w[k])  begin n_err++; $display("FAIL bp_data%0d: got %h want %h", k, tri_wdata, w[k]); end
      if (tri_addr !== 16'(k)) begin n_err++; $display("FAIL bp_addr%0d: got %0d want %0d", k, tri_addr, k); end
      step(2'b00, '0, 1'b1);
    end
    n_cmp++;
    if (tri_we !== 1'b0) begin n_err++; $display("FAIL bp_empty: got %b want 0", tri_we); end
    drain_until_idle(1'b1);
    n_cmp++;
    if (tri_count !== 16'd2) begin n_err++; $display("FAIL bp_count: got %0d want 2", tri_count); end
  endtask

  task automatic test_grant_stalls();
    int cyc, p0, n;
    cyc = 0;
    p0  = ld_pulses;
    for (int i = 0; i < 6; i++) begin
      step(2'b01, DW'(32'h5000 + i), (cyc % 3) == 0);
      cyc++;
      n_cmp++;
      if (tri_addr !== exp_addr()) begin n_err++; $display("FAIL stall_addr%0d: got %0d want %0d", cyc, tri_addr, exp_addr()); end
    end
    step(2'b10, '0, (cyc % 3) == 0);
    cyc++;
    n = 0;
    while (m_phase != PH_IDLE && n < 64) begin
      step(2'b00, '0, (cyc % 3) == 0);
      cyc++; n++;
      n_cmp++;
      if (tri_addr !== exp_addr()) begin n_err++; $display("FAIL stall_addr%0d: got %0d want %0d", cyc, tri_addr, exp_addr()); end
    end
    n_cmp += 3;
    if (m_phase != PH_IDLE)  begin n_err++; $display("FAIL stall_timeout: session never ended, required done"); end
    if (tri_count !== 16'd2) begin n_err++; $display("FAIL stall_count: got %0d want 2", tri_count); end
    if (ld_pulses - p0 != 1) begin n_err++; $display("FAIL stall_pulses: got %0d want 1", ld_pulses - p0); end
  endtask

  task automatic test_partial();
    int p0;
    p0 = ld_pulses;
    for (int i = 0; i < 4; i++) step(2'b01, DW'(32'h7000 + i), 1'b1);
    step(2'b10, '0, 1'b1);
    drain_until_idle(1'b1);
    n_cmp += 3;
    if (tri_count !== 16'd1) begin n_err++; $display("FAIL partial_count: got %0d want 1", tri_count); end
    if (err_proto !== 1'b1)  begin n_err++; $display("FAIL partial_proto: got %b want 1", err_proto); end
    if (ld_pulses - p0 != 1) begin n_err++; $display("FAIL partial_pulses: got %0d want 1", ld_pulses - p0); end
  endtask

  task automatic test_protocol();
    logic [DW-1:0] bad;
    int n;
    bad = {DW/8{8'hEE}};
    for (int i = 0; i < 9; i++) step(2'b01, DW'(32'h9000 + i), 1'b0);
    step(2'b10, '0, 1'b0);
    step(2'b01, bad, 1'b0);
    n_cmp += 2;
    if (err_proto !== 1'b1) begin n_err++; $display("FAIL proto_drain_wr: got %b want 1", err_proto); end
    if (err_ovf !== 1'b1)   begin n_err++; $display("FAIL proto_ovf: got %b want 1", err_ovf); end
    n = 0;
    while (mq.size() != 0 && n < 32) begin
      n_cmp++;
      if (tri_wdata !== mq[0]) begin n_err++; $display("FAIL proto_data: got %h want %h", tri_wdata, mq[0]); end
      step(2'b00, '0, 1'b1);
      n++;
    end
    drain_until_idle(1'b1);
    step(2'b01, DW'(32'hA5A5), 1'b0);
    n_cmp += 4;
    if (err_proto !== 1'b0) begin n_err++; $display("FAIL proto_clear: got %b want 0", err_proto); end
    if (err_ovf !== 1'b0)   begin n_err++; $display("FAIL ovf_clear: got %b want 0", err_ovf); end
    if (tri_addr !== BASE)  begin n_err++; $display("FAIL proto_new_addr: got %0d want %0d", tri_addr, BASE); end
    if (tri_count !== 16'd0) begin n_err++; $display("FAIL proto_new_count: got %0d want 0", tri_count); end
    step(2'b10, '0, 1'b1);
    drain_until_idle(1'b1);
  endtask

  task automatic test_reset_mid_session();
    int p0;
    for (int i = 0; i < 3; i++) step(2'b01, DW'(32'hC000 + i), 1'b0);
    p0 = ld_pulses;
    #2 rst = 1'b1;
    #1;
    n_cmp += 3;
    if (tri_we !== 1'b0)         begin n_err++; $display("FAIL rst_async_we: got %b want 0", tri_we); end
    if (mem_wr_rdy_tri !== 1'b1) begin n_err++; $display("FAIL rst_async_rdy: got %b want 1", mem_wr_rdy_tri); end
    if (busy !== 1'b0)           begin n_err++; $display("FAIL rst_async_busy: got %b want 0", busy); end
    mem_wr_en = 2'b00;
    model_reset();
    repeat (2) begin
      @(negedge clk);
      if (load_done === 1'b1) ld_pulses++;
    end
    rst = 1'b0;
    repeat (2) step(2'b00, '0, 1'b1);
    n_cmp++;
    if (ld_pulses != p0) begin n_err++; $display("FAIL rst_no_pulse: got %0d pulses want 0", ld_pulses - p0); end
    step(2'b01, DW'(32'hD00D), 1'b1);
    n_cmp += 3;
    if (tri_we !== 1'b1)     begin n_err++; $display("FAIL rst_new_we: got %b want 1", tri_we); end
    if (tri_addr !== BASE)   begin n_err++; $display("FAIL rst_new_addr: got %0d want %0d", tri_addr, BASE); end
    if (tri_count !== 16'd0) begin n_err++; $display("FAIL rst_new_count: got %0d want 0", tri_count); end
    step(2'b10, '0, 1'b1);
    drain_until_idle(1'b1);
  endtask

  task automatic test_random();
    logic [1:0]    en;
    logic [DW-1:0] d;
    logic          g;
    int            n_words, cyc;
    for (int s = 0; s < 6; s++) begin
      n_words = $urandom_range(1, 14);
      cyc = 0;
      // Load phase, then done, then drain; occasional stray codes throughout.
      while (cyc < 200 && !(m_phase == PH_IDLE && cyc > 0)) begin
        d = {$urandom, $urandom, $urandom, $urandom};
        g = ($urandom_range(0, 2) != 0);
        if (cyc < n_words) begin
          if (!mem_wr_rdy_tri && $urandom_range(0, 3) != 0) en = 2'b00;
          else en = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'b01;
        end else if (cyc == n_words) begin
          en = 2'b10;
        end else begin
          en = ($urandom_range(0, 15) == 0) ? 2'b01 : 2'b00;
        end
        step(en, d, g);
        cyc++;
        n_cmp += 8;
        if (tri_we !== (mq.size() != 0)) begin n_err++; $display("FAIL rnd_we: got %b want %b", tri_we, mq.size() != 0); end
        if (tri_addr !== exp_addr())     begin n_err++; $display("FAIL rnd_addr: got %0d want %0d", tri_addr, exp_addr()); end
        if (tri_count !== exp_count())   begin n_err++; $display("FAIL rnd_count: got %0d want %0d", tri_count, exp_count()); end
        if (load_done !== (m_phase == PH_DONE)) begin n_err++; $display("FAIL rnd_done: got %b want %b", load_done, m_phase == PH_DONE); end
        if (busy !== (m_phase == PH_LOAD || m_phase == PH_DRAIN)) begin n_err++; $display("FAIL rnd_busy: got %b", busy); end
        if (err_ovf !== m_ovf)           begin n_err++; $display("FAIL rnd_ovf: got %b want %b", err_ovf, m_ovf); end
        if (err_proto !== m_proto)       begin n_err++; $display("FAIL rnd_proto: got %b want %b", err_proto, m_proto); end
        if (mem_wr_rdy_tri !== (mq.size() <= DEPTH - 2)) begin n_err++; $display("FAIL rnd_rdy: got %b want %b", mem_wr_rdy_tri, mq.size() <= DEPTH - 2); end
        if (mq.size() != 0) begin
          n_cmp++;
          if (tri_wdata !== mq[0]) begin n_err++; $display("FAIL rnd_data: got %h want %h", tri_wdata, mq[0]); end
        end
      end
      n_cmp++;
      if (m_phase != PH_IDLE) begin n_err++; $display("FAIL rnd_timeout: session %0d did not finish", s); end
    end
  endtask

  initial begin
    rst             = 1'b1;
    mem_wr_en       = 2'b00;
    mem_wr_data_128 = '0;
    tri_wr_gnt      = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_triangle();
    test_backpressure();
    test_grant_stalls();
    test_partial();
    test_protocol();
    test_reset_mid_session();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_tri_wr_buffer
